data_loader: RTL and testbench
==============================

DATA_LOADER -- requirements
Module: data_loader

Interface
REQ-001 Parameter ADDRESS_MASK_UPPER_4, default 4'h0: a bridge write is accepted only when bridge_addr[31:28] equals this value.
REQ-002 Parameter ADDRESS_SIZE, default 14: write_addr is ADDRESS_SIZE+1 bits wide.
REQ-003 Parameter OUTPUT_WORD_SIZE, default 2, legal values 1, 2 and 4: output word width in bytes.
REQ-004 Parameter WRITE_MEM_CLOCK_DELAY, default 4, minimum 2: clk_74a cycles between consecutive write_en pulses.
REQ-005 Timing is fixed: one clock; reset is asynchronous and active-high.
REQ-006 clk_74a  input  1  sole clock; all logic is rising-edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 bridge_wr  input  1  bridge write strobe, one word per high cycle.
REQ-009 bridge_endian_little  input  1  1: bridge_wr_data[7:0] is the lowest-address byte; 0: bridge_wr_data[31:24] is.
REQ-010 bridge_addr  input  32  byte address of the bridge word.
REQ-011 bridge_wr_data  input  32  bridge write data.
REQ-012 write_en  output  1  one-cycle write strobe.
REQ-013 write_addr  output  ADDRESS_SIZE+1  byte address of the output word.
REQ-014 write_data  output  8*OUTPUT_WORD_SIZE  output word.

Function
REQ-015 On an accepted write, {bridge_addr[ADDRESS_SIZE:0], bridge_endian_little, bridge_wr_data} SHALL be pushed into a 4-entry FIFO in the same cycle.
REQ-016 Byte order: byte k (k=0..3) is bridge_wr_data[8k+7:8k] when little-endian and bridge_wr_data[31-8k:24-8k] when big-endian; byte k belongs at address base+k.
REQ-017 Each word SHALL produce 4/OUTPUT_WORD_SIZE outputs; output i has write_addr = base + i*OUTPUT_WORD_SIZE, and write_data packs bytes i*S..i*S+S-1 with the lowest address in bits [7:0].
REQ-018 Latency: bridge_wr sampled at edge n into an empty, idle FIFO SHALL give write_en high in the cycle after edge n+2; subsequent outputs follow every WRITE_MEM_CLOCK_DELAY cycles.
REQ-019 write_en SHALL be high for exactly one cycle per output word; write_addr and write_data SHALL hold their values until the next output word.
REQ-020 A queued word SHALL begin output WRITE_MEM_CLOCK_DELAY cycles after the final output of the previous word.
REQ-021 A write arriving when the FIFO is full SHALL be dropped; a push and a pop in the same cycle on a full FIFO SHALL both succeed.
REQ-022 Writes with a mismatched upper address nibble SHALL be ignored.
REQ-023 Address arithmetic SHALL wrap modulo 2^(ADDRESS_SIZE+1).

Reset
REQ-024 While reset is asserted, write_en, write_addr and write_data SHALL be 0, the FIFO empty and the sequencer idle; an in-progress word SHALL be discarded.

Configuration
REQ-025 With DATA_LOADER_OVERFLOW_FLAG_EN defined, an extra 1-bit output overflow SHALL go high on the first dropped write and stay high until reset; without the macro the port and its logic SHALL be absent.

Structure
REQ-026 Package data_loader_pkg SHALL hold the FIFO entry struct typedef, the FIFO depth constant and the byte-select function.
REQ-027 The FIFO SHALL be a sub-module named data_loader_fifo, parameterized by width and depth.

Verification
REQ-028 Idle for 10 cycles after reset -> write_en stays 0.
REQ-029 Big-endian, addr 0xC, data 0xAABBCCDD, size 2 -> addr 0xC / data 0xBBAA, then 4 cycles later addr 0xE / data 0xDDCC; each pulse lasts 1 cycle.
REQ-030 Big-endian, addr 0x20, data 0xFFEEDDCC -> addr 0x20 / data 0xEEFF, then addr 0x22 / data 0xCCDD.
REQ-031 Little-endian, addr 0x0, data 0xAABBCCDD, size 2 -> 0xCCDD at 0x0, then 0xAABB at 0x2; size 4 big-endian -> 0xDDCCBBAA at 0x0.
REQ-032 Five back-to-back writes -> first four output in order, fifth dropped; overflow = 1 when the macro is defined.
REQ-033 Write with bridge_addr = 0x1000000C and mask 0 -> no output; reset asserted mid-word -> outputs go to 0 immediately and no further pulses occur.

Source files
------------

// File: rtl/data_loader_pkg.sv
// Shared types and helpers for the bridge-to-memory data loader:
// FIFO entry layout, FIFO depth, sequencer states and byte selection.
package data_loader_pkg;

    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        little;
        logic [31:0] data;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_EMIT = 2'd1,
        SEQ_GAP  = 2'd2
    } seq_state_t;

    // Byte k lives at base+k; big-endian words keep byte 0 in the top lane (3-k == ~k).
    function automatic logic [7:0] select_byte(input logic [31:0] data,
                                               input logic        little,
                                               input logic [1:0]  k);
        logic [4:0] sh;
        sh = little ? {k, 3'b000} : {~k, 3'b000};
        return data[sh +: 8];
    endfunction

endpackage

// File: rtl/data_loader_fifo.sv
// Small synchronous FIFO with show-ahead read; a push on a full FIFO
// succeeds only when a pop happens in the same cycle.
module data_loader_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign rdata   = mem_q[rptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wptr_d  = do_push ? bump(wptr_q) : wptr_q;
        rptr_d  = do_pop ? bump(rptr_q) : rptr_q;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/data_loader.sv
// Splits 32-bit bridge writes into 1/2/4-byte memory writes, paced every
// WRITE_MEM_CLOCK_DELAY cycles. Optional sticky overflow port: DATA_LOADER_OVERFLOW_FLAG_EN.
module data_loader
    import data_loader_pkg::*;
#(
    parameter logic [3:0] ADDRESS_MASK_UPPER_4  = 4'h0,
    parameter int         ADDRESS_SIZE          = 14,
    parameter int         OUTPUT_WORD_SIZE      = 2,
    parameter int         WRITE_MEM_CLOCK_DELAY = 4
) (
    input  logic                          clk_74a,
    input  logic                          reset,
    input  logic                          bridge_wr,
    input  logic                          bridge_endian_little,
    input  logic [31:0]                   bridge_addr,
    input  logic [31:0]                   bridge_wr_data,
    output logic                          write_en,
    output logic [ADDRESS_SIZE:0]         write_addr,
    output logic [8*OUTPUT_WORD_SIZE-1:0] write_data,
    output seq_state_t                    dbg_state
`ifdef DATA_LOADER_OVERFLOW_FLAG_EN
    ,
    output logic                          overflow
`endif
);
    localparam int AW    = ADDRESS_SIZE + 1;
    localparam int DW    = 8 * OUTPUT_WORD_SIZE;
    localparam int WORDS = 4 / OUTPUT_WORD_SIZE;
    localparam int CNT_W = $clog2(WRITE_MEM_CLOCK_DELAY) + 1;

    logic             accept, pop, fifo_empty, fifo_full;
    logic [ENTRY_W-1:0] fifo_rdata;
    fifo_entry_t      push_entry, head;
    logic [AW-1:0]    base;
    logic             unused_ok;

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             write_en_q, write_en_d;
    logic [AW-1:0]    write_addr_q, write_addr_d;
    logic [DW-1:0]    write_data_q, write_data_d;

    assign accept = bridge_wr && (bridge_addr[31:28] == ADDRESS_MASK_UPPER_4);

    always_comb begin
        push_entry                   = '0;
        push_entry.addr[AW-1:0]      = bridge_addr[ADDRESS_SIZE:0];
        push_entry.little            = bridge_endian_little;
        push_entry.data              = bridge_wr_data;
    end

    data_loader_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk_74a),
        .rst  (reset),
        .push (accept),
        .pop  (pop),
        .wdata(push_entry),
        .rdata(fifo_rdata),
        .empty(fifo_empty),
        .full (fifo_full)
    );

    assign head      = fifo_entry_t'(fifo_rdata);
    assign base      = head.addr[AW-1:0];
    assign unused_ok = ^{head.addr, bridge_addr};

    // The head word stays in the FIFO until its last slice is written, so a
    // word being emitted still occupies a FIFO slot.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        pop          = 1'b0;
        write_en_d   = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        case (state_q)
            SEQ_IDLE: begin
                if (!fifo_empty) begin
                    state_d = SEQ_EMIT;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            SEQ_EMIT: begin
                if (cnt_q == '0) begin
                    write_en_d   = 1'b1;
                    write_addr_d = base + AW'(int'(idx_q) * OUTPUT_WORD_SIZE);
                    for (int j = 0; j < OUTPUT_WORD_SIZE; j++) begin
                        write_data_d[8*j +: 8] = select_byte(head.data, head.little,
                                                 2'(int'(idx_q) * OUTPUT_WORD_SIZE + j));
                    end
                    if (idx_q == 2'(WORDS - 1)) begin
                        pop     = 1'b1;
                        idx_d   = '0;
                        state_d = SEQ_GAP;
                        cnt_d   = CNT_W'(WRITE_MEM_CLOCK_DELAY - 2);
                    end else begin
                        idx_d = idx_q + 1'b1;
                        cnt_d = CNT_W'(WRITE_MEM_CLOCK_DELAY - 1);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SEQ_GAP: begin
                // Next word's first write lands exactly one delay after the last one.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!fifo_empty) begin
                    state_d = SEQ_EMIT;
                    idx_d   = '0;
                end else begin
                    state_d = SEQ_IDLE;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            state_q      <= SEQ_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    assign write_en   = write_en_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign dbg_state  = state_q;

`ifdef DATA_LOADER_OVERFLOW_FLAG_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q | (accept && fifo_full && !pop);
    end

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_data_loader.sv
// Bench for data_loader: two instances (2-byte/delay 4 and 4-byte/delay 3)
// share one bridge stimulus and are checked against a schedule-level model.
module tb_data_loader;
    import data_loader_pkg::*;

    localparam int S_A = 2, D_A = 4;
    localparam int S_B = 4, D_B = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bridge_wr = 1'b0;
    logic        bridge_endian_little = 1'b0;
    logic [31:0] bridge_addr = '0;
    logic [31:0] bridge_wr_data = '0;

    logic        we_a, we_b;
    logic [14:0] wa_a, wa_b;
    logic [15:0] wd_a;
    logic [31:0] wd_b;
    seq_state_t  st_a, st_b;
`ifdef DATA_LOADER_OVERFLOW_FLAG_EN
    logic        ov_a, ov_b;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Expected pulses: {edge[31:0], addr[15:0], data[31:0]}
    logic [79:0] exp_q_a[$];
    logic [79:0] exp_q_b[$];
    int          recent_pop[2][4];
    int          recent_ptr[2];
    int          last_final[2];
    int          drop_edge[2];
    logic [15:0] last_addr[2];
    logic [31:0] last_data[2];

    data_loader #(.OUTPUT_WORD_SIZE(S_A), .WRITE_MEM_CLOCK_DELAY(D_A)) dut_a (
        .clk_74a(clk), .reset(reset), .bridge_wr(bridge_wr),
        .bridge_endian_little(bridge_endian_little), .bridge_addr(bridge_addr),
        .bridge_wr_data(bridge_wr_data), .write_en(we_a), .write_addr(wa_a),
        .write_data(wd_a), .dbg_state(st_a)
`ifdef DATA_LOADER_OVERFLOW_FLAG_EN
        , .overflow(ov_a)
`endif
    );

    data_loader #(.OUTPUT_WORD_SIZE(S_B), .WRITE_MEM_CLOCK_DELAY(D_B)) dut_b (
        .clk_74a(clk), .reset(reset), .bridge_wr(bridge_wr),
        .bridge_endian_little(bridge_endian_little), .bridge_addr(bridge_addr),
        .bridge_wr_data(bridge_wr_data), .write_en(we_b), .write_addr(wa_b),
        .write_data(wd_b), .dbg_state(st_b)
`ifdef DATA_LOADER_OVERFLOW_FLAG_EN
        , .overflow(ov_b)
`endif
    );

    // Clock / edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        exp_q_a.delete();
        exp_q_b.delete();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) recent_pop[d][k] = -1000;
            recent_ptr[d] = 0;
            last_final[d] = -1000;
            drop_edge[d]  = 32'h7fff_ffff;
            last_addr[d]  = '0;
            last_data[d]  = '0;
        end
    endtask

    // Word sampled at edge m: first slice at max(m+2, previous final + delay);
    // the word leaves the FIFO at its own final slice.
    task automatic model_write(input int d, input int m, input logic [31:0] addr,
                               input logic little, input logic [31:0] data);
        int s, dly, occ, first, n, base, edge_i, w, b;
        s   = (d == 0) ? S_A : S_B;
        dly = (d == 0) ? D_A : D_B;
        if (addr[31:28] != 4'h0) return;
        occ = 0;
        for (int k = 0; k < 4; k++) if (recent_pop[d][k] > m) occ++;
        if (occ >= 4) begin
            if (drop_edge[d] > m) drop_edge[d] = m;
            return;
        end
        first = (m + 2 > last_final[d] + dly) ? m + 2 : last_final[d] + dly;
        n     = 4 / s;
        base  = int'(addr[14:0]);
        for (int i = 0; i < n; i++) begin
            edge_i = first + i * dly;
            w = 0;
            for (int j = 0; j < s; j++) begin
                int k;
                k = i * s + j;
                b = little ? int'((data >> (8 * k)) & 32'hff) : int'((data >> (24 - 8 * k)) & 32'hff);
                w = w | (b << (8 * j));
            end
            if (d == 0) exp_q_a.push_back({32'(edge_i), 16'((base + i * s) % 32768), 32'(w)});
            else        exp_q_b.push_back({32'(edge_i), 16'((base + i * s) % 32768), 32'(w)});
        end
        last_final[d] = first + (n - 1) * dly;
        recent_pop[d][recent_ptr[d]] = last_final[d];
        recent_ptr[d] = (recent_ptr[d] + 1) % 4;
    endtask

    task automatic mon(input int d, input logic en, input logic [31:0] a, input logic [31:0] dt);
        logic [79:0] f;
        bit have, exp_en;
        have = 0;
        f = '0;
        if (d == 0) begin
            while (exp_q_a.size() > 0 && int'(exp_q_a[0][79:48]) < cyc) void'(exp_q_a.pop_front());
            if (exp_q_a.size() > 0) begin f = exp_q_a[0]; have = 1; end
        end else begin
            while (exp_q_b.size() > 0 && int'(exp_q_b[0][79:48]) < cyc) void'(exp_q_b.pop_front());
            if (exp_q_b.size() > 0) begin f = exp_q_b[0]; have = 1; end
        end
        exp_en = have && (int'(f[79:48]) == cyc);
        check((d == 0) ? "write_en_a" : "write_en_b", 32'(en), 32'(exp_en));
        if (exp_en) begin
            last_addr[d] = f[47:32];
            last_data[d] = f[31:0];
            if (d == 0) void'(exp_q_a.pop_front());
            else        void'(exp_q_b.pop_front());
        end
        check((d == 0) ? "write_addr_a" : "write_addr_b", a, 32'(last_addr[d]));
        check((d == 0) ? "write_data_a" : "write_data_b", dt, last_data[d]);
    endtask

    // Scoreboard: every falling edge
    always @(negedge clk) begin
        mon(0, we_a, 32'(wa_a), 32'(wd_a));
        mon(1, we_b, 32'(wa_b), wd_b);
`ifdef DATA_LOADER_OVERFLOW_FLAG_EN
        check("overflow_a", 32'(ov_a), 32'(cyc >= drop_edge[0]));
        check("overflow_b", 32'(ov_b), 32'(cyc >= drop_edge[1]));
`endif
    end

    // Driver tasks (called right after a falling edge)
    task automatic wr(input logic [31:0] addr, input logic little, input logic [31:0] data);
        bridge_wr            = 1'b1;
        bridge_addr          = addr;
        bridge_endian_little = little;
        bridge_wr_data       = data;
        model_write(0, cyc + 1, addr, little, data);
        model_write(1, cyc + 1, addr, little, data);
        @(negedge clk);
        bridge_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        bridge_wr = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_en_a", 32'(we_a), 32'd0);
        check("reset_state_a", 32'(st_a), 32'(SEQ_IDLE));
        check("reset_state_b", 32'(st_b), 32'(SEQ_IDLE));
        reset = 1'b0;
        idle(10);
        check("idle_en_a", 32'(we_a), 32'd0);
        check("idle_en_b", 32'(we_b), 32'd0);

        wr(32'h0000_000C, 1'b0, 32'hAABB_CCDD); idle(30);
        wr(32'h0000_0020, 1'b0, 32'hFFEE_DDCC); idle(30);
        wr(32'h0000_0000, 1'b1, 32'hAABB_CCDD); idle(30);
        wr(32'h0000_0000, 1'b0, 32'hAABB_CCDD); idle(30);
        wr(32'h0000_7FFE, 1'b1, 32'h1122_3344); idle(30);
        wr(32'h1000_000C, 1'b0, 32'h5566_7788); idle(20);

        for (int i = 0; i < 5; i++) wr(32'h100 + 32'(4 * i), 1'b0, 32'h0102_0304 + 32'(i));
        idle(80);

        // Reset in the middle of a word
        wr(32'h0000_0040, 1'b1, 32'hDEAD_BEEF);
        idle(3);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_mid_en_a", 32'(we_a), 32'd0);
        check("rst_mid_addr_a", 32'(wa_a), 32'd0);
        check("rst_mid_data_a", 32'(wd_a), 32'd0);
        check("rst_mid_data_b", wd_b, 32'd0);
        idle(3);
        reset = 1'b0;
        idle(20);

        for (int i = 0; i < 300; i++) begin
            logic [3:0] nib;
            nib = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            wr({nib, 12'h0, 16'($urandom)}, 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 12));
        end

        begin
            int budget;
            budget = 3000;
            while ((exp_q_a.size() > 0 || exp_q_b.size() > 0) && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            check("drain_timeout", 32'(budget == 0), 32'd0);
        end
        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
